// File: rtl/s27_vector_sequencer_if.sv
// Handshake bundle between the harness, the sequencer and the s27 core.
// master = harness side, slave = sequencer side.
interface s27_vector_sequencer_if;
  logic        start;
  logic        po0;
  logic [3:0]  dut_inputs;
  logic        dut_hold;
  logic        busy;
  logic        done;
  logic [3:0]  vec_idx;
  logic [15:0] resp;

  modport master (
    output start,
    output po0,
    input  dut_inputs,
    input  dut_hold,
    input  busy,
    input  done,
    input  vec_idx,
    input  resp
  );

  modport slave (
    input  start,
    input  po0,
    output dut_inputs,
    output dut_hold,
    output busy,
    output done,
    output vec_idx,
    output resp
  );
endinterface

// File: rtl/s27_vector_sequencer.sv
// Exhaustive 16-vector sequencer for the s27 benchmark core.
// Define S27_SEQ_MISR_EN to compact responses into a 16-bit MISR.
module s27_vector_sequencer #(
  parameter int INIT_CYCLES = 1,
  parameter int DWELL       = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  s27_vector_sequencer_if.slave  bus
);

  localparam int IW = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam int DW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

  generate
    if (INIT_CYCLES < 1 || DWELL < 1) begin : g_param_chk
      $error("s27_vector_sequencer: INIT_CYCLES and DWELL must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_APPLY,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] init_cnt;
  logic [DW-1:0] dwell_cnt;
  logic [3:0]    vec;
  logic [15:0]   resp;
  logic [15:0]   resp_cap;
  logic          init_last;
  logic          dwell_last;
  logic          last_vec;

  assign init_last  = (init_cnt == '0);
  assign dwell_last = (dwell_cnt == '0);
  assign last_vec   = (vec == 4'd15);

`ifdef S27_SEQ_MISR_EN
  assign resp_cap = {resp[14:0], 1'b0}
                  ^ (resp[15] ? 16'h1021 : 16'h0000)
                  ^ {15'b0, bus.po0};
`else
  always_comb begin
    resp_cap      = resp;
    resp_cap[vec] = bus.po0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nx = S_INIT;
      S_INIT:  if (init_last) state_nx = S_APPLY;
      S_APPLY: if (dwell_last && last_vec) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Down-counters reload to N-1 so each phase spans exactly N cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      init_cnt  <= '0;
      dwell_cnt <= '0;
      vec       <= '0;
      resp      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            init_cnt <= IW'(INIT_CYCLES - 1);
            vec      <= '0;
            resp     <= '0;
          end
        end
        S_INIT: begin
          if (init_last) begin
            dwell_cnt <= DW'(DWELL - 1);
          end else begin
            init_cnt <= init_cnt - 1'b1;
          end
        end
        S_APPLY: begin
          if (dwell_last) begin
            resp      <= resp_cap;
            dwell_cnt <= DW'(DWELL - 1);
            vec       <= vec + 4'd1;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.dut_inputs = 4'd0;
    bus.dut_hold   = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.vec_idx    = vec;
    bus.resp       = resp;
    unique case (state)
      S_INIT: begin
        bus.dut_hold = 1'b1;
        bus.busy     = 1'b1;
      end
      S_APPLY: begin
        bus.dut_inputs = vec;
        bus.busy       = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_s27_vector_sequencer.sv
// Directed bench for s27_vector_sequencer: defaults instance plus an
// INIT_CYCLES=3/DWELL=1 instance driving an s27 core model.
module tb_s27_vector_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failed = 0;
  int   mode = 0;

  always #5 clock = ~clock;

  s27_vector_sequencer_if bus_a ();
  s27_vector_sequencer_if bus_b ();

  s27_vector_sequencer dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  s27_vector_sequencer #(
    .INIT_CYCLES (3),
    .DWELL       (1)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  always_comb begin
    bus_a.po0 = 1'b0;
    case (mode)
      0: bus_a.po0 = bus_a.dut_inputs[0];
      1: bus_a.po0 = bus_a.busy && (bus_a.vec_idx == 4'd0);
      default: bus_a.po0 = 1'b0;
    endcase
  end

  // s27 netlist: G0..G3 = inputs, G17 = output, G5/G6/G7 = flops
  logic g5 = 1'b0, g6 = 1'b0, g7 = 1'b0;
  logic g0, g1, g2, g3, g8, g9, g10, g11, g12, g13, g14, g15, g16;
  assign {g3, g2, g1, g0} = bus_b.dut_inputs;
  assign g14 = ~g0;
  assign g8  = g14 & g6;
  assign g12 = ~(g1 | g7);
  assign g15 = g12 | g8;
  assign g16 = g3 | g8;
  assign g9  = ~(g16 & g15);
  assign g11 = ~(g5 | g9);
  assign g10 = ~(g14 | g11);
  assign g13 = ~(g2 | g12);
  assign bus_b.po0 = ~g11;

  always_ff @(posedge clock) begin
    if (bus_b.dut_hold) begin
      g5 <= 1'b0;
      g6 <= 1'b0;
      g7 <= 1'b0;
    end else begin
      g5 <= g10;
      g6 <= g11;
      g7 <= g13;
    end
  end

  function automatic logic [15:0] exp_resp(input logic [15:0] bits);
`ifdef S27_SEQ_MISR_EN
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      r = {r[14:0], 1'b0} ^ (r[15] ? 16'h1021 : 16'h0000) ^ {15'b0, bits[i]};
    end
    return r;
`else
    return bits;
`endif
  endfunction

  function automatic logic [26:0] outs_a();
    return {bus_a.dut_inputs, bus_a.dut_hold, bus_a.busy,
            bus_a.done, bus_a.vec_idx, bus_a.resp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start on instance A, optionally poke start again at cycle `poke`.
  task automatic run_a(input int poke, output int busy_n,
                       output int done_cyc, output logic [15:0] r);
    busy_n   = 0;
    done_cyc = -1;
    r        = 16'hxxxx;
    bus_a.start = 1'b1;
    @(negedge clock);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      bus_a.start = (cyc == poke);
      if (bus_a.busy) busy_n++;
      if (bus_a.done) begin
        done_cyc = cyc;
        r = bus_a.resp;
        break;
      end
      @(negedge clock);
    end
    bus_a.start = 1'b0;
  endtask

  initial begin
    int busy_n;
    int done_cyc;
    logic [15:0] r;
    int k;

    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("reset_outs", 32'(outs_a()), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk($sformatf("idle_outs_%0d", i), 32'(outs_a()), 32'd0);
    end

    // Full run with every cycle checked
    mode = 0;
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      chk($sformatf("busy_c%0d", c), 32'(bus_a.busy), 32'd1);
      chk($sformatf("hold_c%0d", c), 32'(bus_a.dut_hold), 32'(c == 1));
      chk($sformatf("done_c%0d", c), 32'(bus_a.done), 32'd0);
      if (c >= 2)
        chk($sformatf("inputs_c%0d", c), 32'(bus_a.dut_inputs),
            32'((c - 2) / 2));
      @(negedge clock);
    end
    chk("done_c34", 32'(bus_a.done), 32'd1);
    chk("busy_c34", 32'(bus_a.busy), 32'd0);
    chk("inputs_c34", 32'(bus_a.dut_inputs), 32'd0);
    chk("resp_full", 32'(bus_a.resp), 32'(exp_resp(16'hAAAA)));
    @(negedge clock);
    chk("done_c35", 32'(bus_a.done), 32'd0);
    chk("resp_hold", 32'(bus_a.resp), 32'(exp_resp(16'hAAAA)));

    // Start while busy is ignored
    run_a(10, busy_n, done_cyc, r);
    chk("poke_done_cyc", 32'(done_cyc), 32'd34);
    chk("poke_busy_n", 32'(busy_n), 32'd33);
    chk("poke_resp", 32'(r), 32'(exp_resp(16'hAAAA)));
    @(negedge clock);
    chk("poke_no_restart", 32'(bus_a.busy), 32'd0);

    // Reset during vector 7
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    k = 0;
    while (!(bus_a.busy && bus_a.dut_inputs == 4'd7) && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("reach_vec7", 32'(k < 100), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_outs", 32'(outs_a()), 32'd0);
    run_a(0, busy_n, done_cyc, r);
    chk("rerun_done_cyc", 32'(done_cyc), 32'd34);
    chk("rerun_resp", 32'(r), 32'(exp_resp(16'hAAAA)));
    @(negedge clock);

    // po0 high only for vector 0, then po0 low throughout
    mode = 1;
    run_a(0, busy_n, done_cyc, r);
    chk("v0only_done_cyc", 32'(done_cyc), 32'd34);
    chk("v0only_resp", 32'(r), 32'(exp_resp(16'h0001)));
    @(negedge clock);
    mode = 2;
    run_a(0, busy_n, done_cyc, r);
    chk("zero_done_cyc", 32'(done_cyc), 32'd34);
    chk("zero_resp", 32'(r), 32'h0000);
    @(negedge clock);

    // INIT_CYCLES=3, DWELL=1 against the s27 model from state 000
    busy_n = 0;
    done_cyc = -1;
    r = 16'hxxxx;
    k = 0;
    bus_b.start = 1'b1;
    @(negedge clock);
    bus_b.start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (bus_b.busy) busy_n++;
      if (bus_b.dut_hold) k++;
      if (bus_b.done) begin
        done_cyc = cyc;
        r = bus_b.resp;
        break;
      end
      @(negedge clock);
    end
    chk("s27_done_cyc", 32'(done_cyc), 32'd20);
    chk("s27_busy_n", 32'(busy_n), 32'd19);
    chk("s27_hold_n", 32'(k), 32'd3);
    chk("s27_resp", 32'(r), 32'(exp_resp(16'h99FF)));
    @(negedge clock);
    chk("s27_idle", 32'(bus_b.busy | bus_b.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/s27_vector_sequencer.md
# s27_vector_sequencer

Controller that sequences the s27 sequential benchmark core through a deterministic exhaustive test run. On a start pulse it holds the core's state registers cleared for a programmable number of cycles, then applies all 16 values of the 4-bit primary input. Each value is held for a programmable dwell time. It samples `po0` at the end of every vector into a 16-bit response register and reports completion with a one-cycle done pulse. It sits between the simulation/top-level harness and the s27 `top` instance and replaces ad-hoc register forcing and free-running input sweeps.

## Interface
- `INIT_CYCLES`, default 1: cycles `dut_hold` is asserted before the first vector; must be ≥1.
- `DWELL`, default 2: cycles each input vector is held; must be ≥1. Elaboration fails with `$error` if either is 0.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `po0`  in  1  s27 primary output.
- `dut_inputs`  out  4  drives s27 `input_0`..`input_3` (bit i → `input_i`).
- `dut_hold`  out  1  holds s27 state registers at 0 while high.
- `busy`  out  1  high in INIT and APPLY.
- `done`  out  1  one-cycle pulse; `resp` valid from this cycle until next accepted start.
- `vec_idx`  out  4  index of vector currently applied.
- `resp`  out  16  captured responses (or signature, see Configuration).

## Operation
- States: IDLE → INIT → APPLY → DONE → IDLE.
- IDLE:
  - All outputs 0 except `resp`, which holds its last value.
  - `start`=1 at an edge → INIT, `resp` cleared to 0, `vec_idx`=0.
- INIT:
  - `dut_hold`=1, `dut_inputs`=0, `busy`=1.
  - Counts `INIT_CYCLES` cycles, then → APPLY.
- APPLY:
  - `dut_inputs`=`vec_idx`, `dut_hold`=0, `busy`=1.
  - A dwell counter of width $clog2(DWELL+1) counts `DWELL` cycles.
  - On the last dwell cycle's edge, `po0` is captured (raw: `resp[vec_idx]` ← `po0`). Then:
    - `vec_idx`<15: `vec_idx` increments, dwell counter reloads.
    - `vec_idx`=15: → DONE, `vec_idx` wraps to 0.
- DONE: `done`=1, `busy`=0, `dut_inputs`=0; unconditionally → IDLE next edge.
- `start` is ignored in INIT, APPLY and DONE; there is no queuing.
- `reset`=1 at any edge, including mid-run:
  - State → IDLE.
  - `dut_inputs`, `dut_hold`, `busy`, `done`, `vec_idx` and `resp` all become 0.
  - A partial `resp` is discarded.

## Timing
- Reset values: all outputs 0.
- Let E0 be the edge where `start` is accepted:
  - `busy`/`dut_hold` rise after E0.
  - The first vector is presented after E0+`INIT_CYCLES`.
  - Vector i is presented during edges E0+`INIT_CYCLES`+i·`DWELL` .. +(i+1)·`DWELL`; `po0` is sampled at the closing edge.
  - `done` is high for exactly one cycle after E0+`INIT_CYCLES`+16·`DWELL`.
  - Defaults: 33 busy cycles, `done` in cycle 34.
- `po0` is treated as combinational from `dut_inputs` and the s27 state. The sample point is the final dwell edge, so `DWELL`=1 samples the same cycle the vector is driven.
- The earliest restart is `start` in the first IDLE cycle after DONE, i.e. one cycle after the `done` pulse.

## Configuration
- Macro: `S27_SEQ_MISR_EN`.
- **Defined:** `resp` is a 16-bit MISR instead of a raw capture.
  - At each capture: `resp` ← {`resp`[14:0],0} ^ (`resp`[15] ? 16'h1021 : 0) ^ {15'b0,`po0`}.
  - Cleared on start and reset.
- **Undefined:** raw capture only (bit i = `po0` of vector i); no MISR logic is synthesized.
- All timing is identical in both builds.

## Test plan
- **Reset/idle:** hold `reset` 3 cycles, then release with `start`=0 → all outputs 0 for 10 cycles.
- **Full run, raw, defaults:** `po0` tied to `dut_inputs[0]`, pulse `start` → `busy` high 33 cycles, `dut_hold` high first cycle only, `dut_inputs` steps 0..15 every 2 cycles, `done` single pulse, `resp`=16'hAAAA.
- **Start while busy:** pulse `start` again at cycle 10 of a run → no restart, `done` still in cycle 34, `resp` unchanged from the expected single-run value.
- **Reset mid-run:** assert `reset` during vector 7 → next cycle all outputs 0, `resp`=0. A new `start` then completes normally.
- **MISR build:** `S27_SEQ_MISR_EN` defined, `po0`=1 only while `vec_idx`=0 → `resp`=16'h8000 at `done`. With `po0`=0 throughout → `resp`=16'h0000.
- **Parameter sweep:** `INIT_CYCLES`=3, `DWELL`=1 against the real s27 `top` → `done` after 19 busy cycles, `resp` matches the golden model of s27 started from state 000.
